alu_op_sequencer: RTL and testbench

Operand/result sequencer wrapped around the `alu` datapath. It accepts one ALU operation per request handshake and drives `alu`'s operand and one-hot select lines. It captures `alu`'s result and flag outputs, and applies the second-cycle BCD correction that `alu` does not perform. It returns the final byte plus N/Z/C/V on a valid/ready result port. It sits between the instruction decode/register file (upstream) and the status/accumulator write-back (downstream).

---
 rtl/alu_op_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Accepts one ALU operation per request handshake, drives the external
//   `alu` datapath for one cycle, optionally applies the second-cycle BCD
//   correction, and presents the final byte plus N/Z/C/V on a valid/ready
//   result port.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_op/a/b/c/v/decimal  operation, operands, incoming C/V, D flag
//   alu_*  (out)            operands, carry-in, daa and one-hot selects to alu
//   alu_out/acr/hc/avr (in) alu result and flags
//   res_valid/res_ready     result handshake
//   res_data, res_n/z/c/v   final byte and flags, stable while res_valid
module alu_op_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_c,
    input  logic       req_v,
    input  logic       req_decimal,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_i_addc,
    output logic       alu_daa,
    output logic       alu_sums,
    output logic       alu_ands,
    output logic       alu_ors,
    output logic       alu_eors,
    output logic       alu_srs,
    input  logic [7:0] alu_out,
    input  logic       alu_acr,
    input  logic       alu_hc,
    input  logic       alu_avr,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_n,
    output logic       res_z,
    output logic       res_c,
    output logic       res_v
);

    localparam logic [2:0] OP_ADC = 3'd0, OP_SBC = 3'd1, OP_CMP = 3'd2, OP_AND = 3'd3,
                           OP_ORA = 3'd4, OP_EOR = 3'd5, OP_LSR = 3'd6, OP_ROR = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, ADJUST, DONE} state_t;

    state_t     state, state_nx;

    logic [2:0] op_q;
    logic [7:0] a_q, b_q;
    logic       c_q, v_q, d_q;
    logic [7:0] cap_out;
    logic       cap_acr, cap_hc, cap_avr;

    logic       dec_path;
    logic       accept;
    logic       load_res;
    logic [7:0] fin;
    logic       fin_c, fin_v;
    logic [3:0] lo_add, hi_add;

    // Decimal mode only matters for ADC/SBC; CMP and logic/shift ignore D.
    assign dec_path = d_q && (op_q == OP_ADC || op_q == OP_SBC);
    assign accept   = req_valid && (state == IDLE);
    assign load_res = (state == EXEC && !dec_path) || (state == ADJUST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = EXEC;
            EXEC:    state_nx = dec_path ? ADJUST : DONE;
            ADJUST:  state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: alu lines are driven only in EXEC, zero elsewhere.
    always_comb begin
        req_ready  = (state == IDLE);
        res_valid  = (state == DONE);
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        alu_i_addc = 1'b0;
        alu_daa    = 1'b0;
        alu_sums   = 1'b0;
        alu_ands   = 1'b0;
        alu_ors    = 1'b0;
        alu_eors   = 1'b0;
        alu_srs    = 1'b0;
        if (state == EXEC) begin
            alu_a = a_q;
            case (op_q)
                OP_ADC: begin alu_sums = 1'b1; alu_b = b_q;  alu_i_addc = c_q; alu_daa = d_q; end
                OP_SBC: begin alu_sums = 1'b1; alu_b = ~b_q; alu_i_addc = c_q; end
                OP_CMP: begin alu_sums = 1'b1; alu_b = ~b_q; alu_i_addc = 1'b1; end
                OP_AND: begin alu_ands = 1'b1; alu_b = b_q; end
                OP_ORA: begin alu_ors  = 1'b1; alu_b = b_q; end
                OP_EOR: begin alu_eors = 1'b1; alu_b = b_q; end
                OP_LSR: begin alu_srs  = 1'b1; end
                default: begin alu_srs = 1'b1; alu_i_addc = c_q; end  // ROR
            endcase
        end
    end

    // Final byte/flags: straight from alu in EXEC, BCD-corrected in ADJUST.
    // Each nibble is corrected independently (4-bit wrap, no inter-nibble carry).
    always_comb begin
        if (op_q == OP_ADC) begin
            lo_add = cap_hc  ? 4'h6 : 4'h0;
            hi_add = cap_acr ? 4'h6 : 4'h0;
        end else begin
            lo_add = cap_hc  ? 4'h0 : 4'hA;
            hi_add = cap_acr ? 4'h0 : 4'hA;
        end
        if (state == ADJUST) begin
            fin   = {cap_out[7:4] + hi_add, cap_out[3:0] + lo_add};
            fin_c = cap_acr;
            fin_v = cap_avr;
        end else begin
            fin   = alu_out;
            fin_c = (op_q == OP_AND || op_q == OP_ORA || op_q == OP_EOR) ? c_q : alu_acr;
            fin_v = (op_q == OP_ADC || op_q == OP_SBC) ? alu_avr : v_q;
        end
    end

    // Request latch, alu capture and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 3'd0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            d_q      <= 1'b0;
            cap_out  <= 8'h00;
            cap_acr  <= 1'b0;
            cap_hc   <= 1'b0;
            cap_avr  <= 1'b0;
            res_data <= 8'h00;
            res_n    <= 1'b0;
            res_z    <= 1'b0;
            res_c    <= 1'b0;
            res_v    <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
                c_q  <= req_c;
                v_q  <= req_v;
                d_q  <= req_decimal;
            end
            if (state == EXEC) begin
                cap_out <= alu_out;
                cap_acr <= alu_acr;
                cap_hc  <= alu_hc;
                cap_avr <= alu_avr;
            end
            if (load_res) begin
                res_data <= fin;
                res_n    <= fin[7];
                res_z    <= (fin == 8'h00);
                res_c    <= fin_c;
                res_v    <= fin_v;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a, req_b;
    logic       req_c, req_v, req_decimal;
    logic [7:0] alu_a, alu_b;
    logic       alu_i_addc, alu_daa;
    logic       alu_sums, alu_ands, alu_ors, alu_eors, alu_srs;
    logic [7:0] alu_out;
    logic       alu_acr, alu_hc, alu_avr;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_n, res_z, res_c, res_v;

    int tests = 0;
    int fails = 0;

    // Override lets a step emulate alu's decimal behaviour on ADC.
    logic       ovr_en;
    logic [7:0] ovr_out;
    logic       ovr_hc, ovr_acr, ovr_avr;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_v(req_v),
        .req_decimal(req_decimal),
        .alu_a(alu_a), .alu_b(alu_b), .alu_i_addc(alu_i_addc), .alu_daa(alu_daa),
        .alu_sums(alu_sums), .alu_ands(alu_ands), .alu_ors(alu_ors),
        .alu_eors(alu_eors), .alu_srs(alu_srs),
        .alu_out(alu_out), .alu_acr(alu_acr), .alu_hc(alu_hc), .alu_avr(alu_avr),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_n(res_n), .res_z(res_z), .res_c(res_c), .res_v(res_v)
    );

    // Binary model of the external alu; garbage when nothing is selected.
    logic [8:0] sum;
    logic [4:0] lsum;
    always_comb begin
        sum     = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_i_addc};
        lsum    = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'h0, alu_i_addc};
        alu_out = 8'h5A;
        alu_acr = 1'b1;
        alu_hc  = 1'b1;
        alu_avr = 1'b1;
        if (alu_sums) begin
            alu_out = sum[7:0];
            alu_acr = sum[8];
            alu_hc  = lsum[4];
            alu_avr = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
            if (ovr_en) begin
                alu_out = ovr_out;
                alu_hc  = ovr_hc;
                alu_acr = ovr_acr;
                alu_avr = ovr_avr;
            end
        end else if (alu_ands) begin
            alu_out = alu_a & alu_b; alu_acr = 1'b0; alu_avr = 1'b0;
        end else if (alu_ors) begin
            alu_out = alu_a | alu_b; alu_acr = 1'b0; alu_avr = 1'b0;
        end else if (alu_eors) begin
            alu_out = alu_a ^ alu_b; alu_acr = 1'b0; alu_avr = 1'b0;
        end else if (alu_srs) begin
            alu_out = {alu_i_addc, alu_a[7:1]}; alu_acr = alu_a[0]; alu_avr = 1'b0;
        end
    end

    wire [4:0] sel = {alu_sums, alu_ands, alu_ors, alu_eors, alu_srs};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one op and run it to DONE, checking drive, latency and result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a, b,
                          input logic c, v, d, input logic [4:0] esel, input logic [7:0] eb,
                          input logic eaddc, edaa, input logic dec,
                          input logic [7:0] ed, input logic en, ez, ec, ev);
        chk({tag, ".ready"}, req_ready, 1'b1);
        req_op = op; req_a = a; req_b = b; req_c = c; req_v = v; req_decimal = d;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk({tag, ".sel"},  sel, esel);
        chk({tag, ".alu_a"}, alu_a, a);
        chk({tag, ".alu_b"}, alu_b, eb);
        chk({tag, ".addc"}, alu_i_addc, eaddc);
        chk({tag, ".daa"},  alu_daa, edaa);
        chk({tag, ".vld_exec"}, res_valid, 1'b0);
        tick();
        if (dec) begin
            chk({tag, ".vld_adj"}, res_valid, 1'b0);
            chk({tag, ".sel_adj"}, sel, 5'b00000);
            tick();
        end
        chk({tag, ".vld"}, res_valid, 1'b1);
        chk({tag, ".sel_done"}, sel, 5'b00000);
        chk({tag, ".data"}, res_data, ed);
        chk({tag, ".nzcv"}, {res_n, res_z, res_c, res_v}, {en, ez, ec, ev});
    endtask

    task automatic release_res(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, ".vld_off"}, res_valid, 1'b0);
        chk({tag, ".rdy_on"}, req_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
        req_op = 3'd0; req_a = 8'h00; req_b = 8'h00;
        req_c = 1'b0; req_v = 1'b0; req_decimal = 1'b0;
        ovr_en = 1'b0; ovr_out = 8'h00; ovr_hc = 1'b0; ovr_acr = 1'b0; ovr_avr = 1'b0;
        #12;
        chk("rst.ready", req_ready, 1'b1);
        chk("rst.valid", res_valid, 1'b0);
        chk("rst.data",  res_data, 8'h00);
        chk("rst.nzcv",  {res_n, res_z, res_c, res_v}, 4'b0000);
        chk("rst.alu",   {alu_a, alu_b, alu_i_addc, alu_daa, sel}, 23'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //            tag       op    a      b      c     v     d     sel       alu_b  addc  daa  dec   data   N Z C V
        run_op("adc_bin", 3'd0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 5'b10000, 8'h50, 1'b0, 1'b0, 1'b0, 8'hA0, 1, 0, 0, 1);
        release_res("adc_bin");

        ovr_en = 1'b1; ovr_out = 8'hAF; ovr_hc = 1'b1; ovr_acr = 1'b1; ovr_avr = 1'b0;
        run_op("adc_dec", 3'd0, 8'h58, 8'h46, 1'b1, 1'b0, 1'b1, 5'b10000, 8'h46, 1'b1, 1'b1, 1'b1, 8'h05, 0, 0, 1, 0);
        release_res("adc_dec");
        ovr_en = 1'b0;

        run_op("sbc_dec", 3'd1, 8'h42, 8'h13, 1'b1, 1'b0, 1'b1, 5'b10000, 8'hEC, 1'b1, 1'b0, 1'b1, 8'h29, 0, 0, 1, 0);
        release_res("sbc_dec");

        // D set on CMP must not add the adjust cycle
        run_op("cmp",     3'd2, 8'h10, 8'h20, 1'b1, 1'b1, 1'b1, 5'b10000, 8'hDF, 1'b1, 1'b0, 1'b0, 8'hF0, 1, 0, 0, 1);
        release_res("cmp");

        run_op("ror",     3'd7, 8'h01, 8'h77, 1'b1, 1'b0, 1'b0, 5'b00001, 8'h00, 1'b1, 1'b0, 1'b0, 8'h80, 1, 0, 1, 0);
        release_res("ror");

        run_op("lsr",     3'd6, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 5'b00001, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1, 1, 0);
        release_res("lsr");

        run_op("and",     3'd3, 8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0, 5'b01000, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1, 1, 0);
        release_res("and");

        run_op("ora",     3'd4, 8'h12, 8'h40, 1'b0, 1'b0, 1'b0, 5'b00100, 8'h40, 1'b0, 1'b0, 1'b0, 8'h52, 0, 0, 0, 0);
        release_res("ora");

        // Backpressure: result held while new requests are offered and ignored
        run_op("eor",     3'd5, 8'h3C, 8'hFF, 1'b0, 1'b1, 1'b0, 5'b00010, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hC3, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_op = 3'(i); req_a = 8'(i * 37); req_b = 8'(i * 11 + 1);
            req_c = i[0]; req_v = i[1];
            tick();
            chk("bp.data",  res_data, 8'hC3);
            chk("bp.nzcv",  {res_n, res_z, res_c, res_v}, 4'b1001);
            chk("bp.valid", res_valid, 1'b1);
            chk("bp.ready", req_ready, 1'b0);
            chk("bp.sel",   sel, 5'b00000);
        end
        req_valid = 1'b0;
        release_res("bp");

        // Reset during EXEC abandons the op
        req_op = 3'd0; req_a = 8'h11; req_b = 8'h22; req_c = 1'b0; req_decimal = 1'b0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("mr.in_exec", sel, 5'b10000);
        #2 rst_n = 1'b0;
        #1;
        chk("mr.ready", req_ready, 1'b1);
        chk("mr.sel",   sel, 5'b00000);
        chk("mr.data",  res_data, 8'h00);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr.valid", res_valid, 1'b0);
            chk("mr.idle",  req_ready, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
